// File: rtl/mux2x1_arbiter_pkg.sv
// Shared constants for the two-requester arbiter: default widths, requester
// indices and the output-stage state encoding.
package mux2x1_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Output stage state is the out_valid bit itself
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

endpackage

// File: rtl/Mux2x1.sv
// Plain 2:1 word mux: sel=0 passes e1, sel=1 passes e2.
module Mux2x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] e2,
  input  logic             sel,
  output logic [WIDTH-1:0] y_c
);

  assign y_c = sel ? e2 : e1;

endmodule

// File: rtl/rr_pick2.sv
// Two-way winner selection with a last-grant register; round-robin when FAIR,
// otherwise requester 0 has fixed priority.
module rr_pick2
  import mux2x1_arbiter_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic winner_c,
  output logic grant_c
);

  logic last_grant;

  // With no request the winner parks on last_grant so sel stays steady
  always_comb begin
    winner_c = last_grant;
    unique case ({valid1, valid0})
      2'b01:   winner_c = REQ0;
      2'b10:   winner_c = REQ1;
      2'b11:   winner_c = (FAIR != 0) ? ~last_grant : REQ0;
      default: winner_c = last_grant;
    endcase
  end

  assign grant_c = advance & (valid0 | valid1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
    end else if (grant_c) begin
      last_grant <= winner_c;
    end
  end

endmodule

// File: rtl/mux2x1_arbiter.sv
// Arbitrates two valid/ready requesters onto one registered output channel,
// steering the shared Mux2x1 and counting accepted words per requester.
module mux2x1_arbiter
  import mux2x1_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FAIR  = 1,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             src_q, src_nxt;
  logic [CNT_W-1:0] cnt0_q, cnt0_nxt;
  logic [CNT_W-1:0] cnt1_q, cnt1_nxt;
  logic             load_en_c;
  logic             winner_c;
  logic             grant_c;
  logic [WIDTH-1:0] mux_y_c;

  // Output stage can take a word when empty or when being drained this cycle
  assign load_en_c = (state_q == EMPTY) | out_ready;

  rr_pick2 #(
    .FAIR (FAIR)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .advance  (load_en_c),
    .winner_c (winner_c),
    .grant_c  (grant_c)
  );

  Mux2x1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .e1  (req0_data),
    .e2  (req1_data),
    .sel (winner_c),
    .y_c (mux_y_c)
  );

  assign sel        = winner_c;
  assign req0_ready = load_en_c & req0_valid & (winner_c == REQ0);
  assign req1_ready = load_en_c & req1_valid & (winner_c == REQ1);

  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    src_nxt   = src_q;
    cnt0_nxt  = cnt0_q;
    cnt1_nxt  = cnt1_q;

    unique case (state_q)
      EMPTY: begin
        if (grant_c) state_nxt = FULL;
      end
      FULL: begin
        if (grant_c)        state_nxt = FULL;
        else if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase

    if (grant_c) begin
      data_nxt = mux_y_c;
      src_nxt  = winner_c;
      if (winner_c == REQ0) begin
        if (cnt0_q != CNT_MAX) cnt0_nxt = cnt0_q + CNT_W'(1);
      end else begin
        if (cnt1_q != CNT_MAX) cnt1_nxt = cnt1_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= REQ0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_nxt;
      data_q  <= data_nxt;
      src_q   <= src_nxt;
      cnt0_q  <= cnt0_nxt;
      cnt1_q  <= cnt1_nxt;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Directed bench: round-robin, fixed-priority and 4-bit-counter arbiters share
// one stimulus stream; each step checks against hand-computed values.
module tb_mux2x1_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, out_ready;
  logic [31:0] req0_data, req1_data;

  logic        f_r0, f_r1, f_ov, f_src, f_sel;
  logic [31:0] f_od;
  logic [15:0] f_c0, f_c1;

  logic        x_r0, x_r1, x_ov, x_src, x_sel;
  logic [31:0] x_od;
  logic [15:0] x_c0, x_c1;

  logic        s_r0, s_r1, s_ov, s_src, s_sel;
  logic [31:0] s_od;
  logic [3:0]  s_c0, s_c1;

  int vectors = 0;
  int miscompares = 0;

  mux2x1_arbiter #(.WIDTH(32), .FAIR(1), .CNT_W(16)) u_fair (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(f_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(f_r1),
    .out_valid(f_ov), .out_data(f_od), .out_src(f_src), .out_ready(out_ready),
    .sel(f_sel), .cnt0(f_c0), .cnt1(f_c1)
  );

  mux2x1_arbiter #(.WIDTH(32), .FAIR(0), .CNT_W(16)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(x_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(x_r1),
    .out_valid(x_ov), .out_data(x_od), .out_src(x_src), .out_ready(out_ready),
    .sel(x_sel), .cnt0(x_c0), .cnt1(x_c1)
  );

  mux2x1_arbiter #(.WIDTH(32), .FAIR(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
    .out_valid(s_ov), .out_data(s_od), .out_src(s_src), .out_ready(out_ready),
    .sel(s_sel), .cnt0(s_c0), .cnt1(s_c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    req0_data = '0; req1_data = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(f_ov), 32'd0);
    chk("rst_out_data", f_od, 32'd0);
    chk("rst_out_src", 32'(f_src), 32'd0);
    chk("rst_cnt0", 32'(f_c0), 32'd0);
    chk("rst_cnt1", 32'(f_c1), 32'd0);

    // Single requester: accept in cycle 0, visible in cycle 1
    #10;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h0000_00AA; out_ready = 1'b1;
    #1;
    chk("single_req0_ready", 32'(f_r0), 32'd1);
    chk("single_req1_ready", 32'(f_r1), 32'd0);
    chk("single_sel", 32'(f_sel), 32'd0);
    tick();
    chk("single_out_valid", 32'(f_ov), 32'd1);
    chk("single_out_data", f_od, 32'h0000_00AA);
    chk("single_out_src", 32'(f_src), 32'd0);
    chk("single_cnt0", 32'(f_c0), 32'd1);

    // Drain with no grant: empties, data kept, counters untouched
    req0_valid = 1'b0;
    tick();
    chk("drain_out_valid", 32'(f_ov), 32'd0);
    chk("drain_out_data", f_od, 32'h0000_00AA);
    chk("drain_cnt0", 32'(f_c0), 32'd1);

    // Two more req0 words to reach cnt0=3
    req0_valid = 1'b1; req0_data = 32'h0000_0033;
    tick();
    chk("two_cnt0_a", 32'(f_c0), 32'd2);
    tick();
    chk("two_cnt0_b", 32'(f_c0), 32'd3);
    req0_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_rst_out_valid", 32'(f_ov), 32'd1);

    // Asynchronous reset between edges takes effect immediately
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(f_ov), 32'd0);
    chk("midrst_cnt0", 32'(f_c0), 32'd0);
    chk("midrst_out_data", f_od, 32'd0);
    rst_n = 1'b1;

    // Both valid: first grant after reset goes to req0
    req0_valid = 1'b1; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_data = 32'h2222_2222;
    out_ready = 1'b1;
    #1;
    chk("both_first_r0", 32'(f_r0), 32'd1);
    chk("both_first_r1", 32'(f_r1), 32'd0);
    chk("fix_first_r0", 32'(x_r0), 32'd1);

    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rr_out_data", f_od, (i % 2 == 1) ? 32'h1111_1111 : 32'h2222_2222);
      chk("rr_out_src", 32'(f_src), (i % 2 == 1) ? 32'd0 : 32'd1);
      chk("rr_next_r1", 32'(f_r1), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("fix_out_data", x_od, 32'h1111_1111);
      chk("fix_r1", 32'(x_r1), 32'd0);
    end
    chk("rr_cnt0", 32'(f_c0), 32'd3);
    chk("rr_cnt1", 32'(f_c1), 32'd3);
    chk("fix_cnt0", 32'(x_c0), 32'd6);
    chk("fix_cnt1", 32'(x_c1), 32'd0);

    // Backpressure: full and stalled, nothing accepted, output held
    out_ready = 1'b0;
    req0_valid = 1'b0;
    req1_data = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_r0", 32'(f_r0), 32'd0);
      chk("bp_r1", 32'(f_r1), 32'd0);
      chk("bp_out_data", f_od, 32'h2222_2222);
      chk("bp_out_valid", 32'(f_ov), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_r1", 32'(f_r1), 32'd1);
    tick();
    chk("bp_new_data", f_od, 32'h0000_0055);
    chk("bp_new_src", 32'(f_src), 32'd1);
    chk("bp_cnt1", 32'(f_c1), 32'd4);

    // Saturation on the 4-bit counter: starts at 3, 20 more req0 words
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_0077;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 11) chk("sat_cnt0_14", 32'(s_c0), 32'd14);
      if (i == 12) chk("sat_cnt0_15", 32'(s_c0), 32'd15);
    end
    chk("sat_cnt0_final", 32'(s_c0), 32'd15);
    chk("sat_cnt1_hold", 32'(s_c1), 32'd4);
    chk("wide_cnt0_final", 32'(f_c0), 32'd23);
    req0_valid = 1'b0;
    tick();
    chk("final_drain", 32'(f_ov), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
